amstrad_mem_arbiter: RTL and testbench

Shares one external memory port (SDRAM controller front-end) between three requesters: the Gate Array video fetch, the Z80 CPU, and the ROM/disk loader. It sits between the motherboard and the SDRAM controller. It replaces the fixed CPU/video time-slotting with a request/acknowledge scheduler, and gives the CPU a wait line so that any memory latency is tolerated.

---
 rtl/amstrad_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_amstrad_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/amstrad_mem_arbiter.sv
// Request/acknowledge scheduler sharing one SDRAM front-end port between
// Gate Array video fetch, the Z80 CPU and the ROM/disk loader.
module amstrad_mem_arbiter #(
    parameter int AW          = 23,
    parameter int LD_MAX_SKIP = 4
) (
    input  logic          clk,
    input  logic          reset,
    // video fetch
    input  logic          vid_req,
    input  logic [14:0]   vid_addr,
    output logic [15:0]   vid_data,
    output logic          vid_valid,
    output logic          vid_overrun,
    // Z80 CPU
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic          cpu_wait,
    // loader
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_busy,
    // memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_ack
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRC_VID = 2'd0,
        SRC_CPU = 2'd1,
        SRC_LD  = 2'd2
    } src_t;

    localparam logic [2:0] SKIP_MAX = 3'(LD_MAX_SKIP);

    // Byte lane of a 16-bit memory word selected by the byte address LSB.
    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
        pick_byte = hi ? word[15:8] : word[7:0];
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;
    src_t          owner_r;
    src_t          sel_src_s;

    logic          grant_vid_s;
    logic          grant_cpu_s;
    logic          grant_ld_s;
    logic          issue_s;
    logic          done_s;

    logic          vpend_r;
    logic [14:0]   vaddr_r;

    logic          cpu_strobe_s;
    logic          cpu_rise_s;
    logic          cpu_strobe_d_r;
    logic          cpend_r;
    logic [AW-1:0] caddr_r;
    logic          cwe_r;
    logic [7:0]    cdata_r;
    logic          cpu_done_r;

    logic          ld_accept_s;
    logic          lpend_r;
    logic [AW-1:0] laddr_r;
    logic [7:0]    ldata_r;
    logic [2:0]    skip_r;

    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [7:0]    sel_wdata_s;

    logic          mem_req_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [7:0]    mem_wdata_r;
    logic [15:0]   vid_data_r;
    logic          vid_valid_r;
    logic          vid_overrun_r;
    logic [7:0]    cpu_din_r;
    logic          ld_busy_r;

    assign cpu_strobe_s = cpu_rd | cpu_wr;
    assign cpu_rise_s   = cpu_strobe_s & ~cpu_strobe_d_r;
    // A loader pulse while the previous write is still outstanding is dropped.
    assign ld_accept_s  = ld_wr & ~ld_busy_r;
    assign issue_s      = grant_vid_s | grant_cpu_s | grant_ld_s;
    assign done_s       = (state_r == ST_BUSY) & mem_ack;

    assign mem_req      = mem_req_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign vid_data     = vid_data_r;
    assign vid_valid    = vid_valid_r;
    assign vid_overrun  = vid_overrun_r;
    assign cpu_din      = cpu_din_r;
    assign ld_busy      = ld_busy_r;
    assign cpu_wait     = cpu_strobe_s & ~cpu_done_r;

    // Next-state and winner selection; the loader overtakes the CPU once it has been skipped enough.
    always_comb begin
        state_nxt_s = state_r;
        grant_vid_s = 1'b0;
        grant_cpu_s = 1'b0;
        grant_ld_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (vpend_r) begin
                    grant_vid_s = 1'b1;
                end else if (cpend_r && !(lpend_r && (skip_r == SKIP_MAX))) begin
                    grant_cpu_s = 1'b1;
                end else if (lpend_r) begin
                    grant_ld_s = 1'b1;
                end else begin
                    grant_vid_s = 1'b0;
                end
                if (vpend_r || cpend_r || lpend_r) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Address/data/direction of the granted requester.
    always_comb begin
        sel_src_s   = SRC_VID;
        sel_we_s    = 1'b0;
        sel_addr_s  = {{(AW-16){1'b0}}, vaddr_r, 1'b0};
        sel_wdata_s = 8'h00;
        if (grant_cpu_s) begin
            sel_src_s   = SRC_CPU;
            sel_we_s    = cwe_r;
            sel_addr_s  = caddr_r;
            sel_wdata_s = cdata_r;
        end else if (grant_ld_s) begin
            sel_src_s   = SRC_LD;
            sel_we_s    = 1'b1;
            sel_addr_s  = laddr_r;
            sel_wdata_s = ldata_r;
        end else begin
            sel_src_s   = SRC_VID;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Video pending latch; a second request before issue replaces the address and flags overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpend_r       <= 1'b0;
            vaddr_r       <= 15'd0;
            vid_overrun_r <= 1'b0;
        end else begin
            if (vid_req) begin
                vpend_r <= 1'b1;
                vaddr_r <= vid_addr;
                if (vpend_r && !grant_vid_s) begin
                    vid_overrun_r <= 1'b1;
                end
            end else if (grant_vid_s) begin
                vpend_r <= 1'b0;
            end
        end
    end

    // CPU pending latch, captured on the rising edge of the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_strobe_d_r <= 1'b0;
            cpend_r        <= 1'b0;
            caddr_r        <= '0;
            cwe_r          <= 1'b0;
            cdata_r        <= 8'h00;
        end else begin
            cpu_strobe_d_r <= cpu_strobe_s;
            if (cpu_rise_s) begin
                cpend_r <= 1'b1;
                caddr_r <= cpu_addr;
                cwe_r   <= cpu_wr;
                cdata_r <= cpu_dout;
            end else if (grant_cpu_s) begin
                cpend_r <= 1'b0;
            end
        end
    end

    // CPU completion flag; released once the CPU drops both strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_done_r <= 1'b0;
        end else if (!cpu_strobe_s) begin
            cpu_done_r <= 1'b0;
        end else if (done_s && (owner_r == SRC_CPU)) begin
            cpu_done_r <= 1'b1;
        end
    end

    // Loader pending latch and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lpend_r   <= 1'b0;
            laddr_r   <= '0;
            ldata_r   <= 8'h00;
            ld_busy_r <= 1'b0;
        end else begin
            if (ld_accept_s) begin
                lpend_r   <= 1'b1;
                laddr_r   <= ld_addr;
                ldata_r   <= ld_data;
                ld_busy_r <= 1'b1;
            end else begin
                if (grant_ld_s) begin
                    lpend_r <= 1'b0;
                end
                if (done_s && (owner_r == SRC_LD)) begin
                    ld_busy_r <= 1'b0;
                end
            end
        end
    end

    // Count CPU grants that bypass a waiting loader write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_r <= 3'd0;
        end else if (grant_ld_s) begin
            skip_r <= 3'd0;
        end else if (grant_cpu_s && lpend_r && (skip_r < SKIP_MAX)) begin
            skip_r <= skip_r + 3'd1;
        end
    end

    // Memory command registers; address and data hold until the next issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 8'h00;
            owner_r     <= SRC_VID;
        end else begin
            mem_req_r <= issue_s;
            if (issue_s) begin
                mem_we_r    <= sel_we_s;
                mem_addr_r  <= sel_addr_s;
                mem_wdata_r <= sel_wdata_s;
                owner_r     <= sel_src_s;
            end
        end
    end

    // Result delivery on acknowledge; acks outside BUSY never reach here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_data_r  <= 16'h0000;
            vid_valid_r <= 1'b0;
            cpu_din_r   <= 8'h00;
        end else begin
            vid_valid_r <= done_s && (owner_r == SRC_VID);
            if (done_s && (owner_r == SRC_VID)) begin
                vid_data_r <= mem_rdata;
            end
            if (done_s && (owner_r == SRC_CPU) && !mem_we_r) begin
                cpu_din_r <= pick_byte(mem_rdata, mem_addr_r[0]);
            end
        end
    end

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Directed bench for amstrad_mem_arbiter with a fixed-latency memory responder.
module tb_amstrad_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic [15:0] vid_data;
    logic        vid_valid;
    logic        vid_overrun;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [22:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_wait;
    logic        ld_wr;
    logic [22:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_busy;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    amstrad_mem_arbiter #(.AW(23), .LD_MAX_SKIP(4)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_overrun(vid_overrun),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_wait(cpu_wait),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_busy(ld_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Memory responder: lat_cfg = 0 acks in the mem_req cycle, otherwise after a countdown.
    int          lat_cfg   = 3;
    logic [15:0] rdata_cfg = 16'h0000;
    int          ack_cnt   = 0;
    logic        ack_r     = 1'b0;
    always @(posedge clk) begin
        ack_r <= 1'b0;
        if (mem_req && lat_cfg != 0) begin
            ack_cnt <= lat_cfg;
        end else if (ack_cnt > 0) begin
            ack_cnt <= ack_cnt - 1;
            if (ack_cnt == 1) ack_r <= 1'b1;
        end
    end
    assign mem_ack   = (lat_cfg == 0) ? mem_req : ack_r;
    assign mem_rdata = rdata_cfg;

    // Monitor: issued commands, vid_valid pulses, last ack cycle.
    int          cyc = 0;
    int          last_ack_cyc = -1;
    int          vv_total = 0;
    logic [22:0] q_addr[$];
    logic [7:0]  q_wd[$];
    int          q_cyc[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_ack) last_ack_cyc <= cyc;
        if (vid_valid) vv_total <= vv_total + 1;
        if (mem_req) begin
            q_addr.push_back(mem_addr);
            q_wd.push_back(mem_wdata);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int b;
        int vb;
        reset = 1'b1; vid_req = 1'b0; vid_addr = 15'd0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 23'd0; cpu_dout = 8'h00;
        ld_wr = 1'b0; ld_addr = 23'd0; ld_data = 8'h00;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 23'd0);
        chk("rst_vid_valid", vid_valid, 1'b0);
        chk("rst_overrun", vid_overrun, 1'b0);
        chk("rst_ld_busy", ld_busy, 1'b0);
        chk("rst_cpu_wait", cpu_wait, 1'b0);
        chk("rst_vid_data", vid_data, 16'h0000);
        chk("rst_cpu_din", cpu_din, 8'h00);

        // Video fetch, latency 3
        rdata_cfg = 16'hBEEF; b = q_addr.size(); vb = vv_total;
        vid_req = 1'b1; vid_addr = 15'h1234;
        tick(1);
        vid_req = 1'b0;
        chk("vid_req_not_yet", mem_req, 1'b0);
        tick(1);
        chk("vid_mem_req", mem_req, 1'b1);
        chk("vid_mem_addr", mem_addr, 23'h002468);
        chk("vid_mem_we", mem_we, 1'b0);
        tick(1);
        chk("vid_req_pulse", mem_req, 1'b0);
        for (int i = 0; i < 20 && !vid_valid; i++) tick(1);
        chk("vid_valid_seen", vid_valid, 1'b1);
        chk("vid_data", vid_data, 16'hBEEF);
        tick(5);
        chk("vid_valid_count", vv_total - vb, 1);
        chk("vid_issue_count", q_addr.size() - b, 1);

        // CPU read of the odd byte
        rdata_cfg = 16'hA55A;
        cpu_addr = 23'h004001; cpu_rd = 1'b1;
        #1;
        chk("cpu_wait_rises", cpu_wait, 1'b1);
        for (int i = 0; i < 20 && cpu_wait; i++) tick(1);
        chk("cpu_wait_falls", cpu_wait, 1'b0);
        chk("cpu_wait_after_ack", cyc - last_ack_cyc, 1);
        chk("cpu_din", cpu_din, 8'hA5);
        chk("cpu_rd_addr", mem_addr, 23'h004001);
        cpu_rd = 1'b0;
        tick(2);

        // CPU write
        cpu_addr = 23'h000010; cpu_dout = 8'h3C; cpu_wr = 1'b1;
        for (int i = 0; i < 10 && !mem_req; i++) tick(1);
        chk("cpu_wr_req", mem_req, 1'b1);
        chk("cpu_wr_we", mem_we, 1'b1);
        chk("cpu_wr_wdata", mem_wdata, 8'h3C);
        chk("cpu_wr_addr", mem_addr, 23'h000010);
        for (int i = 0; i < 20 && cpu_wait; i++) tick(1);
        chk("cpu_wr_done", cpu_wait, 1'b0);
        chk("cpu_din_held", cpu_din, 8'hA5);
        cpu_wr = 1'b0;
        tick(3);

        // Simultaneous requests, zero ack latency; second loader pulse is dropped
        lat_cfg = 0; b = q_addr.size();
        vid_req = 1'b1; vid_addr = 15'h0010;
        cpu_addr = 23'h000101; cpu_rd = 1'b1;
        ld_wr = 1'b1; ld_addr = 23'h000300; ld_data = 8'h77;
        tick(1);
        vid_req = 1'b0;
        chk("ld_busy_set", ld_busy, 1'b1);
        ld_addr = 23'h000400; ld_data = 8'h99;
        tick(1);
        ld_wr = 1'b0;
        tick(12);
        cpu_rd = 1'b0;
        chk("prio_count", q_addr.size() - b, 3);
        chk("prio_first_vid", q_addr[b], 23'h000020);
        chk("prio_second_cpu", q_addr[b+1], 23'h000101);
        chk("prio_third_ld", q_addr[b+2], 23'h000300);
        chk("ld_data_kept", q_wd[b+2], 8'h77);
        chk("spacing_1", q_cyc[b+1] - q_cyc[b], 2);
        chk("spacing_2", q_cyc[b+2] - q_cyc[b+1], 2);
        chk("ld_busy_clear", ld_busy, 1'b0);
        tick(3);

        // Loader starvation bound with back-to-back CPU requests
        lat_cfg = 1; b = q_addr.size();
        cpu_addr = 23'h000100; cpu_rd = 1'b1;
        ld_wr = 1'b1; ld_addr = 23'h000200; ld_data = 8'h55;
        tick(1);
        ld_wr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cpu_rd = ~cpu_rd;
            tick(1);
        end
        cpu_rd = 1'b0;
        tick(12);
        chk("skip_enough", (q_addr.size() - b) >= 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("skip_order_%0d", i), q_addr[b+i],
                (i == 4) ? 23'h000200 : 23'h000100);
        end
        chk("skip_cleared", dut.skip_r, 3'd0);
        chk("skip_ld_busy", ld_busy, 1'b0);

        // Video overrun while memory is busy with a CPU write
        lat_cfg = 3; rdata_cfg = 16'hCAFE; b = q_addr.size(); vb = vv_total;
        cpu_addr = 23'h000050; cpu_dout = 8'h11; cpu_wr = 1'b1;
        tick(2);
        vid_req = 1'b1; vid_addr = 15'h0100;
        tick(1);
        vid_addr = 15'h0200;
        tick(1);
        vid_req = 1'b0;
        chk("overrun_set", vid_overrun, 1'b1);
        for (int i = 0; i < 20 && cpu_wait; i++) tick(1);
        cpu_wr = 1'b0;
        tick(15);
        chk("ovr_count", q_addr.size() - b, 2);
        chk("ovr_cpu_addr", q_addr[b], 23'h000050);
        chk("ovr_vid_addr", q_addr[b+1], 23'h000400);
        chk("ovr_vid_valid", vv_total - vb, 1);
        chk("ovr_vid_data", vid_data, 16'hCAFE);
        chk("overrun_sticky", vid_overrun, 1'b1);

        // Reset in the middle of a video access; the late ack must be ignored
        rdata_cfg = 16'h2222; vb = vv_total;
        vid_req = 1'b1; vid_addr = 15'h0005;
        tick(1);
        vid_req = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(8);
        chk("rstmid_no_valid", vv_total - vb, 0);
        chk("rstmid_cpu_done", dut.cpu_done_r, 1'b0);
        chk("rstmid_vid_data", vid_data, 16'h0000);
        chk("rstmid_mem_addr", mem_addr, 23'd0);
        chk("rstmid_mem_req", mem_req, 1'b0);
        chk("rstmid_overrun", vid_overrun, 1'b0);
        chk("rstmid_cpu_din", cpu_din, 8'h00);
        rdata_cfg = 16'h1357; b = q_addr.size();
        vid_req = 1'b1; vid_addr = 15'h0007;
        tick(1);
        vid_req = 1'b0;
        for (int i = 0; i < 20 && !vid_valid; i++) tick(1);
        chk("post_rst_valid", vid_valid, 1'b1);
        chk("post_rst_data", vid_data, 16'h1357);
        chk("post_rst_addr", q_addr[b], 23'h00000E);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
